// File: rtl/axis_hdr_insert_fifo.sv
// AXI-Stream header inserter: prepends a queued 0..N byte header to each payload packet and repacks into full beats.
// Optional checker output err_out is built when AXIS_HDR_INS_CHK_EN is defined.
module axis_hdr_insert_fifo #(
    parameter int DATA_WD        = 32,
    parameter int DATA_BYTE_WD   = DATA_WD / 8,
    parameter int BYTE_CNT_WD    = $clog2(DATA_BYTE_WD),
    parameter int HDR_FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic [DATA_WD-1:0]       data_in,
    input  logic [DATA_BYTE_WD-1:0]  keep_in,
    input  logic                     las_in,
    output logic                     ready_in,
    output logic                     valid_out,
    output logic [DATA_WD-1:0]       data_out,
    output logic [DATA_BYTE_WD-1:0]  keep_out,
    output logic                     last_out,
    input  logic                     ready_out,
    input  logic                     valid_insert,
    input  logic [DATA_WD-1:0]       data_insert,
    input  logic [DATA_BYTE_WD-1:0]  keep_insert,
    input  logic [BYTE_CNT_WD:0]     byte_insert_cnt,
    output logic                     ready_insert
`ifdef AXIS_HDR_INS_CHK_EN
    ,
    output logic                     err_out
`endif
);

    localparam int PTR_WD = $clog2(HDR_FIFO_DEPTH);
    localparam logic [BYTE_CNT_WD:0]   NB  = (BYTE_CNT_WD + 1)'(DATA_BYTE_WD);
    localparam logic [BYTE_CNT_WD+1:0] NB2 = (BYTE_CNT_WD + 2)'(DATA_BYTE_WD);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

    function automatic logic [BYTE_CNT_WD:0] f_popcnt(input logic [DATA_BYTE_WD-1:0] k);
        logic [BYTE_CNT_WD:0] c;
        c = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++)
            c = c + {{BYTE_CNT_WD{1'b0}}, k[i]};
        return c;
    endfunction

    function automatic logic [BYTE_CNT_WD:0] f_sat(input logic [BYTE_CNT_WD:0] c);
        return (c > NB) ? NB : c;
    endfunction

    // MSB-first contiguous keep with n bytes set
    function automatic logic [DATA_BYTE_WD-1:0] f_keep(input logic [BYTE_CNT_WD+1:0] n);
        logic [DATA_BYTE_WD-1:0] k;
        k = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++)
            k[DATA_BYTE_WD-1-i] = (i < int'(n));
        return k;
    endfunction

    function automatic logic [DATA_WD-1:0] f_bytes(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++)
            m[i*8 +: 8] = {8{k[i]}};
        return m;
    endfunction

    state_t                   r_state;
    logic [DATA_WD-1:0]       r_fifo_data [HDR_FIFO_DEPTH];
    logic [BYTE_CNT_WD:0]     r_fifo_h    [HDR_FIFO_DEPTH];
    logic [PTR_WD-1:0]        r_wr_ptr;
    logic [PTR_WD-1:0]        r_rd_ptr;
    logic [PTR_WD:0]          r_count;
    logic [BYTE_CNT_WD:0]     r_h;
    logic [DATA_WD-1:0]       r_res;
    logic [DATA_BYTE_WD-1:0]  r_fkeep;

    logic                     w_adv;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_accept;
    logic                     w_push;
    logic                     w_pop;
    logic [BYTE_CNT_WD:0]     w_h;
    logic [DATA_WD-1:0]       w_pre;
    logic [DATA_WD-1:0]       w_merged;
    logic [DATA_WD-1:0]       w_tail;
    logic [BYTE_CNT_WD:0]     w_l;
    logic [BYTE_CNT_WD+1:0]   w_t;
    logic                     w_overflow;
    logic [DATA_BYTE_WD-1:0]  w_last_keep;
    logic [DATA_BYTE_WD-1:0]  w_flush_keep;

    assign w_adv   = !valid_out || ready_out;
    assign w_full  = (r_count == (PTR_WD + 1)'(HDR_FIFO_DEPTH));
    assign w_empty = (r_count == '0);

    always_comb begin
        ready_in = 1'b0;
        case (r_state)
            S_IDLE:   ready_in = w_adv && !w_empty;
            S_STREAM: ready_in = w_adv;
            default:  ready_in = 1'b0;
        endcase
    end

    assign w_accept = valid_in && ready_in;
    assign w_pop    = w_accept && (r_state == S_IDLE);
    // A pop in the same cycle frees a slot, so a full FIFO can still take a push
    assign ready_insert = !w_full || w_pop;
    assign w_push   = valid_insert && ready_insert;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_WD'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_WD'(1);
            if (w_push && !w_pop)
                r_count <= r_count + (PTR_WD + 1)'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - (PTR_WD + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= data_insert;
            r_fifo_h[r_wr_ptr]    <= f_sat(byte_insert_cnt);
        end
    end

    // Prefix is the header in IDLE and the previous beat's tail afterwards; both are right-aligned
    assign w_h      = (r_state == S_IDLE) ? r_fifo_h[r_rd_ptr]    : r_h;
    assign w_pre    = (r_state == S_IDLE) ? r_fifo_data[r_rd_ptr] : r_res;
    assign w_merged = DATA_WD'({w_pre, data_in} >> {w_h, 3'b000});
    assign w_tail   = data_in << {NB - w_h, 3'b000};

    assign w_l          = f_popcnt(keep_in);
    assign w_t          = {1'b0, w_h} + {1'b0, w_l};
    assign w_overflow   = (w_t > NB2);
    assign w_last_keep  = f_keep(w_t);
    assign w_flush_keep = f_keep(w_t - NB2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
            r_h       <= '0;
            r_res     <= '0;
            r_fkeep   <= '0;
        end else if (w_adv) begin
            valid_out <= 1'b0;
            case (r_state)
                S_IDLE, S_STREAM: begin
                    if (w_accept) begin
                        valid_out <= 1'b1;
                        r_h       <= w_h;
                        if (!las_in) begin
                            data_out <= w_merged;
                            keep_out <= '1;
                            last_out <= 1'b0;
                            r_res    <= data_in;
                            r_state  <= S_STREAM;
                        end else if (w_overflow) begin
                            data_out <= w_merged;
                            keep_out <= '1;
                            last_out <= 1'b0;
                            r_res    <= w_tail & f_bytes(w_flush_keep);
                            r_fkeep  <= w_flush_keep;
                            r_state  <= S_FLUSH;
                        end else begin
                            data_out <= w_merged & f_bytes(w_last_keep);
                            keep_out <= w_last_keep;
                            last_out <= 1'b1;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                S_FLUSH: begin
                    valid_out <= 1'b1;
                    data_out  <= r_res;
                    keep_out  <= r_fkeep;
                    last_out  <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef AXIS_HDR_INS_CHK_EN
    logic w_err;
    assign w_err = (w_push && (f_popcnt(keep_insert) != f_sat(byte_insert_cnt)))
                || (w_accept && !las_in && (keep_in != '1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_out <= 1'b0;
        else
            err_out <= w_err;
    end
`else
    logic w_unused_keep_insert;
    assign w_unused_keep_insert = ^keep_insert;
`endif

endmodule

// File: doc/axis_hdr_insert_fifo.md
Name: axis_hdr_insert_fifo

Overview:
Parametrised AXI-Stream header inserter for the AXI_Stream_insert_header datapath. It prepends a variable-length header (0..DATA_BYTE_WD bytes) to every payload packet and repacks the merged byte stream into full output beats. Headers are queued in an internal FIFO, so the header source can run ahead of the payload by up to HDR_FIFO_DEPTH packets. Output is registered and runs at one beat per cycle, except for one flush beat when the last beat overflows.

Parameters:
DATA_WD, 32, payload/header bus width in bits; multiple of 8, minimum 16.
DATA_BYTE_WD, DATA_WD/8, bytes per beat (derived).
BYTE_CNT_WD, $clog2(DATA_BYTE_WD), byte-count width (derived).
HDR_FIFO_DEPTH, 4, header FIFO entries; power of 2, minimum 2.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  payload beat valid
data_in  in  DATA_WD  payload; byte 0 = [DATA_WD-1 -: 8], sent first
keep_in  in  DATA_BYTE_WD  MSB-first contiguous; all ones except possibly on the last beat
las_in  in  1  last payload beat
ready_in  out  1  payload ready
valid_out  out  1  output valid
data_out  out  DATA_WD  merged stream, MSB-first
keep_out  out  DATA_BYTE_WD  MSB-first contiguous
last_out  out  1  last output beat
ready_out  in  1  downstream ready
valid_insert  in  1  header valid
data_insert  in  DATA_WD  header, right-aligned (valid bytes are the LSBs)
keep_insert  in  DATA_BYTE_WD  header keep (1111>>n form)
byte_insert_cnt  in  BYTE_CNT_WD+1  header length H; values >DATA_BYTE_WD saturate to DATA_BYTE_WD
ready_insert  out  1  header FIFO not full

Behaviour:
- Reset: one clock, asynchronous active-low reset (clk, rst_n). All of the following clear immediately on reset assertion:
  - valid_out=0, data_out=0, keep_out=0, last_out=0
  - header FIFO empty, so ready_insert=1
  - FSM goes to IDLE and the residue register is cleared
  - a packet in progress is discarded; no partial last_out is emitted
- Header FIFO:
  - push on valid_insert&&ready_insert; each entry is {data_insert, H}
  - pop on acceptance of the first payload beat of a packet
  - push and pop in the same cycle are allowed when full; count is unchanged
- Output register advances when !valid_out||ready_out ("adv"). Latency is 1 cycle from an accepted input beat to the corresponding valid_out.
- FSM states:
  - IDLE: ready_in = adv && fifo_not_empty. On accept:
    - H and the header are latched
    - output = H header bytes followed by the first N-H payload bytes
    - the trailing H payload bytes are stored as residue
    - go to STREAM, or handle the beat as a last beat if las_in is set
  - STREAM: ready_in = adv. Each accepted beat outputs residue (H bytes) followed by the first N-H input bytes; the residue is then updated.
  - Last beat, with L = popcount(keep_in) and T = H+L:
    - T <= N: one beat, keep_out = top T bits, last_out=1, go to IDLE
    - T > N: full beat with last_out=0, then go to FLUSH
  - FLUSH: ready_in=0. Emits T-N bytes with last_out=1 when adv, then goes to IDLE.
- Unused data_out bytes are driven 0.
- H=0: pure pass-through; data_out/keep_out equal the input delayed 1 cycle; FLUSH is never entered.
- H=N: every payload beat is delayed by one beat; the last beat always flushes unless L=0 is presented (illegal).
- A single-beat packet is legal: header and payload are merged in IDLE.
- valid_out/data_out are held stable while valid_out&&!ready_out.
- keep_insert is ignored functionally; H comes from byte_insert_cnt.

Optional Feature:
AXIS_HDR_INS_CHK_EN
- Defined: adds output port err_out (1 bit, reset 0). err_out pulses for 1 cycle on either condition:
  - a header push where popcount(keep_insert) != saturated byte_insert_cnt
  - an accepted payload beat with las_in=0 and keep_in != all-ones
  - Datapath behaviour is unchanged.
- Undefined: no err_out port and no checking logic.

Test Plan:
- H=3, header 0x00AABBCC; payload 0x11223344, 0x55667788 (keep 1111, last on beat 2); ready_out=1 -> outputs 0xAABBCC11/1111, 0x22334455/1111, then 0x66778800/1110 with last_out=1 (FLUSH).
- H=1, header 0x000000DD; single beat 0x11223344, keep 1100, last -> one beat 0xDD112200, keep 1110, last_out=1; no flush.
- H=0, beat 0xCAFEF00D, keep 1111, last -> 0xCAFEF00D/1111/last exactly 1 cycle later.
- Repeat scenario 1 with ready_out toggling 1,0,1,0 -> identical beat sequence; data held stable while stalled; ready_in=0 in every cycle where adv=0.
- With valid_in=0, push 5 headers (DEPTH=4) -> ready_insert=0 after the 4th, 5th waits; then 4 packets consume headers in FIFO order; ready_in=0 in IDLE while FIFO empty.
- Assert rst_n=0 mid-packet after beat 1 -> outputs go to 0 immediately and ready_insert=1; after release, scenario 2 produces the correct result.
